multistep_shift_reg: RTL and testbench
======================================

# multistep_shift_reg

Parametrised successor to the 4-bit load/shift register. It adds configurable width, four fill modes (logical, arithmetic, rotate, serial) and a valid/ready command interface. Shifts larger than MAX_STEP bits are applied over several cycles by a small state machine. It serves as the shared shift/rotate datapath register for control units that need more than single-cycle 4-bit shifting.

## Interface
- WIDTH, 8, data width in bits; must be at least 2.
- MAX_STEP, 2, maximum bits shifted per clock; range 1..WIDTH-1.
- CNT_W, $clog2(WIDTH), shift-count width; derived, not overridden.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high exactly when the state is IDLE.
- ld  in  1  load command, highest priority.
- sr  in  1  shift right, second priority.
- sl  in  1  shift left, third priority.
- mode  in  2  fill mode: 00 logical, 01 arithmetic, 10 rotate, 11 serial.
- s_cnt  in  CNT_W  total shift amount, 0..WIDTH-1.
- d_in  in  WIDTH  load data.
- ser_in  in  1  fill bit for serial mode; sampled at every step edge.
- abort  in  1  cancels an in-progress multi-cycle shift.
- q  out  WIDTH  register contents.
- busy  out  1  high in the SHIFT state.
- done  out  1  one-cycle pulse marking command completion.

## Operation
- States: IDLE and SHIFT.
- Accept: a command is accepted on a rising edge with cmd_valid && cmd_ready.
- Command decode, priority ld > sr > sl:
  - ld: q <= d_in.
  - Neither ld, sr nor sl set: no-op; q unchanged, done still pulses.
  - sr/sl with s_cnt == 0: q unchanged, done pulses.
- Latched at accept: direction, mode and remaining count (rem = s_cnt). Changes to these inputs while busy have no effect.
- Steps: every step, including the one on the accept edge, shifts by step = min(rem, MAX_STEP), then rem -= step.
  - rem == 0 after the step: done <= 1 and the state is IDLE.
  - Otherwise: the state becomes SHIFT and busy = 1.
- Fill rules per step:
  - Logical: vacated bits are 0.
  - Arithmetic: sr fills with the MSB of q before the step; sl fills with 0.
  - Rotate: bits shifted out re-enter at the opposite end.
  - Serial: all vacated bits of this step take the value of ser_in at that edge.
- Internal arithmetic: rem is CNT_W bits; shifts are computed WIDTH bits wide, with no overflow beyond WIDTH.
- cmd_valid while busy: not accepted and not queued; the requester holds it until cmd_ready.
- abort:
  - In SHIFT: at the next edge the state returns to IDLE, the pending step is not applied, q holds and done stays low.
  - In IDLE: ignored.
- abort on the same edge as the final step: abort wins; no step, no done.

## Timing
- Reset values (asynchronous, immediate): q = 0, state = IDLE, busy = 0, done = 0, rem = 0. cmd_ready = 1 after rst deasserts.
- Reset in the middle of SHIFT: all of the above take effect immediately; the command is lost.
- ld and single-step commands: q is updated at the accept edge; done is high for the following cycle; cmd_ready stays high, so back-to-back commands run every cycle.
- Shift of N bits: ceil(N/MAX_STEP) edges, counting the accept edge. q holds the final value and done = 1 in the cycle after the last edge.
- cmd_ready is low from the accept edge until the last step edge, then high in the same cycle as done.
- done lasts exactly one cycle. It is registered, with no combinational path from inputs.
- q, busy and done are registered. cmd_ready decodes state only.

## Test plan
All scenarios use WIDTH=8, MAX_STEP=2.
- Load and trivial shift: ld with d_in=8'hA5 -> q=8'hA5 after one edge, done for 1 cycle, busy never high. Then sr with s_cnt=0 -> q stays 8'hA5, done pulses.
- Rotate: q=8'h81, mode=10, sr, s_cnt=5 -> q goes 8'h60, 8'h18, 8'h0C over 3 edges. cmd_ready is low for the 2 cycles between them; done comes with 8'h0C. A second cmd_valid during busy is not accepted.
- Arithmetic: q=8'h90, mode=01, sr, s_cnt=3 -> q goes 8'hE4 then 8'hF2; done follows. The same command with mode=00 ends at 8'h12.
- Serial: q=8'h01, mode=11, sl, s_cnt=3, ser_in=1 at the first edge and 0 at the second -> q goes 8'h07 then 8'h0E.
- Abort: q=8'hFF, mode=00, sl, s_cnt=7 -> q goes 8'hFC, 8'hF0. With abort high at the third edge -> q stays 8'hF0, done stays 0, cmd_ready = 1 in the next cycle.
- Reset mid-shift: rst pulsed between two clock edges during busy -> q=0, busy=0, done=0 immediately. After release, ld with 8'h3C is accepted on the first edge.

Source files
------------

// File: rtl/multistep_shift_reg.sv
// Parametrised load/shift register with logical, arithmetic, rotate and serial fill.
// Shifts longer than MAX_STEP bits are split over several cycles behind a valid/ready handshake.
module multistep_shift_reg #(
  parameter int WIDTH    = 8,
  parameter int MAX_STEP = 2,
  parameter int CNT_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             ld,
  input  logic             sr,
  input  logic             sl,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] s_cnt,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_in,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CNT_W-1:0] MAX_S = CNT_W'(MAX_STEP);

  state_t           state;
  logic [CNT_W-1:0] rem;
  logic             dir_right;
  logic [1:0]       mode_l;

  logic [CNT_W-1:0] cur_rem;
  logic [CNT_W-1:0] step;
  logic [CNT_W-1:0] rem_next;
  logic             cur_right;
  logic [1:0]       cur_mode;
  logic [WIDTH-1:0] q_step;

  // Shift through a double-width word: the upper/lower half supplies the fill bits.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] v,
    input logic             right,
    input logic [1:0]       md,
    input logic [CNT_W-1:0] k,
    input logic             ser
  );
    logic [WIDTH-1:0]   fill;
    logic [2*WIDTH-1:0] wide;
    case (md)
      2'b00:   fill = '0;
      2'b01:   fill = right ? {WIDTH{v[WIDTH-1]}} : '0;
      2'b10:   fill = v;
      default: fill = {WIDTH{ser}};
    endcase
    if (right) begin
      wide = {fill, v} >> k;
      return wide[WIDTH-1:0];
    end else begin
      wide = {v, fill} << k;
      return wide[2*WIDTH-1:WIDTH];
    end
  endfunction

  // In IDLE the step is taken from the live command; in SHIFT from the latched one.
  always_comb begin
    cur_rem   = (state == IDLE) ? s_cnt : rem;
    cur_right = (state == IDLE) ? sr    : dir_right;
    cur_mode  = (state == IDLE) ? mode  : mode_l;
    step      = (cur_rem > MAX_S) ? MAX_S : cur_rem;
    rem_next  = cur_rem - step;
    q_step    = shift_step(q, cur_right, cur_mode, step, ser_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      q         <= '0;
      rem       <= '0;
      dir_right <= 1'b0;
      mode_l    <= 2'b00;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (ld) begin
              q    <= d_in;
              done <= 1'b1;
            end else if (sr || sl) begin
              dir_right <= sr;
              mode_l    <= mode;
              q         <= q_step;
              rem       <= rem_next;
              if (rem_next == '0) done  <= 1'b1;
              else                state <= SHIFT;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            q   <= q_step;
            rem <= rem_next;
            if (rem_next == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == SHIFT);

endmodule

// File: tb/tb_multistep_shift_reg.sv
// Bench for multistep_shift_reg: directed walk-through of the documented scenarios,
// then randomized commands checked cycle by cycle against a behavioural model.
module tb_multistep_shift_reg;

  localparam int W  = 8;
  localparam int MS = 2;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, ld, sr, sl, ser_in, abort;
  logic [1:0]    mode;
  logic [CW-1:0] s_cnt;
  logic [W-1:0]  d_in;
  logic          cmd_ready, busy, done;
  logic [W-1:0]  q;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] m_q;
  logic         m_busy, m_done, m_right;
  logic [1:0]   m_mode;
  int           m_rem;

  multistep_shift_reg #(.WIDTH(W), .MAX_STEP(MS)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .ld(ld), .sr(sr), .sl(sl), .mode(mode), .s_cnt(s_cnt), .d_in(d_in),
    .ser_in(ser_in), .abort(abort), .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One shift of k bits expressed with plain operators.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input logic right,
                                             input logic [1:0] md, input int k, input logic ser);
    logic signed [W-1:0] sv;
    logic [W-1:0] base, vac;
    if (k == 0) return v;
    sv = v;
    if (right) begin
      base = v >> k;
      vac  = ~({W{1'b1}} >> k);
      case (md)
        2'b00:   return base;
        2'b01:   return sv >>> k;
        2'b10:   return base | (v << (W - k));
        default: return ser ? (base | vac) : base;
      endcase
    end else begin
      base = v << k;
      vac  = ~({W{1'b1}} << k);
      case (md)
        2'b10:   return base | (v >> (W - k));
        2'b11:   return ser ? (base | vac) : base;
        default: return base;
      endcase
    end
  endfunction

  task automatic model_reset();
    m_q = '0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_right = 1'b0; m_mode = 2'b00;
  endtask

  task automatic model_do_step();
    int k;
    k = (m_rem < MS) ? m_rem : MS;
    m_q   = ref_shift(m_q, m_right, m_mode, k, ser_in);
    m_rem = m_rem - k;
    if (m_rem == 0) begin
      m_busy = 1'b0;
      m_done = 1'b1;
    end else begin
      m_busy = 1'b1;
    end
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (m_busy) begin
      if (abort) m_busy = 1'b0;
      else       model_do_step();
    end else if (cmd_valid) begin
      if (ld) begin
        m_q = d_in;
        m_done = 1'b1;
      end else if (sr || sl) begin
        m_right = sr;
        m_mode  = mode;
        m_rem   = int'(s_cnt);
        model_do_step();
      end else begin
        m_done = 1'b1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("q", 32'(q), 32'(m_q));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
  endtask

  task automatic set_cmd(input logic v, input logic l, input logic r, input logic lf,
                         input logic [1:0] md, input logic [CW-1:0] n, input logic [W-1:0] d);
    cmd_valid = v; ld = l; sr = r; sl = lf; mode = md; s_cnt = n; d_in = d;
  endtask

  task automatic load(input logic [W-1:0] d);
    set_cmd(1, 1, 0, 0, 2'b00, 0, d);
    tick();
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; ser_in = 1'b0;
    set_cmd(0, 0, 0, 0, 2'b00, 0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;

    // load and zero-count shift
    load(8'hA5);
    chk("ld_q", 32'(q), 32'hA5);
    set_cmd(1, 0, 1, 0, 2'b00, 0, '0);
    tick();
    chk("sr0_q", 32'(q), 32'hA5);

    // rotate right by 5, with a rejected command while busy
    load(8'h81);
    set_cmd(1, 0, 1, 0, 2'b10, 5, '0);
    tick();
    chk("rot_1", 32'(q), 32'h60);
    set_cmd(1, 1, 0, 0, 2'b00, 0, 8'hFF);
    tick();
    chk("rot_2", 32'(q), 32'h18);
    tick();
    chk("rot_3", 32'(q), 32'h0C);
    chk("rot_done", 32'(done), 32'h1);

    // arithmetic vs logical right by 3
    load(8'h90);
    set_cmd(1, 0, 1, 0, 2'b01, 3, '0);
    tick();
    chk("ari_1", 32'(q), 32'hE4);
    cmd_valid = 1'b0;
    tick();
    chk("ari_2", 32'(q), 32'hF2);
    load(8'h90);
    set_cmd(1, 0, 1, 0, 2'b00, 3, '0);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("log_q", 32'(q), 32'h12);

    // serial left by 3
    load(8'h01);
    set_cmd(1, 0, 0, 1, 2'b11, 3, '0);
    ser_in = 1'b1;
    tick();
    chk("ser_1", 32'(q), 32'h07);
    cmd_valid = 1'b0; ser_in = 1'b0;
    tick();
    chk("ser_2", 32'(q), 32'h0E);

    // abort on the edge that would apply the third step
    load(8'hFF);
    set_cmd(1, 0, 0, 1, 2'b00, 7, '0);
    tick();
    chk("abt_1", 32'(q), 32'hFC);
    cmd_valid = 1'b0;
    tick();
    chk("abt_2", 32'(q), 32'hF0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_q", 32'(q), 32'hF0);
    chk("abt_done", 32'(done), 32'h0);
    chk("abt_ready", 32'(cmd_ready), 32'h1);

    // asynchronous reset in the middle of a shift
    load(8'hFF);
    set_cmd(1, 0, 0, 1, 2'b00, 7, '0);
    tick();
    cmd_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_q", 32'(q), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    load(8'h3C);
    chk("post_rst_ld", 32'(q), 32'h3C);

    // randomized commands
    for (int i = 0; i < 2000; i++) begin
      cmd_valid = ($urandom_range(0, 9) < 7);
      ld        = ($urandom_range(0, 9) == 0);
      sr        = $urandom_range(0, 1);
      sl        = $urandom_range(0, 1);
      mode      = 2'($urandom_range(0, 3));
      s_cnt     = CW'($urandom_range(0, W - 1));
      d_in      = W'($urandom);
      ser_in    = $urandom_range(0, 1);
      abort     = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
